// File: rtl/sram_bus_pkg.sv
// Shared constants for the external SRAM bus: pin widths, default strobe
// width and the access-sequencer state encoding.
package sram_bus_pkg;

  // SRAM pin widths, also used by the data-collection and UART blocks.
  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 8;

  // Default strobe width in clocks (legal 1..15, fits the 4-bit counter).
  localparam int ACC_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } sram_state_t;

  // Counter preload for a strobe of acc clocks; the counter ends at zero.
  function automatic logic [3:0] strobe_load(input int acc);
    return 4'(acc - 1);
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the port
// not granted last wins. The last-grant pointer resets to 1 so that port 0
// wins the first tie.
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_port
);

  logic last_gnt;

  // Pick the winning port from the current requests and the pointer.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_port  = ~last_gnt;
      end
      default: ;
    endcase
  end

  // Remember who was served when the sequencer accepts a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (take && gnt_valid) begin
      last_gnt <= gnt_port;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one external async SRAM bus between the data-collection writer
// (port 0) and the UART sender reader (port 1). Each access runs
// SETUP -> STROBE (ACC_CYCLES clocks) -> HOLD, followed by a mandatory IDLE
// clock. All SRAM pins come straight from registers.
// Optional access statistics are built when SRAM_BUS_ARBITER_STAT_EN is
// defined: wr_cnt/rd_cnt saturating counters with a synchronous stat_clr.
module sram_bus_arbiter
  import sram_bus_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int AW         = SRAM_AW,
  parameter int DW         = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] ab,
  inout  wire  [DW-1:0] db,
  output logic          cs_n,
  output logic          wr_n,
  output logic          rd_n
`ifdef SRAM_BUS_ARBITER_STAT_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
`endif
);

  sram_state_t   state;
  logic [3:0]    cnt;
  logic          gnt_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          db_oe;
  logic          gnt_valid;
  logic          gnt_port;
  logic          take;

  // Grants are only accepted in IDLE; requests elsewhere wait.
  assign take = (state == ST_IDLE);

  sram_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1, req0}),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  // Data pins are driven only while a write owns the bus; the enable is a
  // register cleared asynchronously, so reset releases db at once.
  assign db   = db_oe ? wdata_q : 'z;
  assign busy = (state != ST_IDLE);

  // Access sequencer: state plus every SRAM pin and the ack pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses <= so all registers update together
      // from the values seen before the edge.
      state   <= ST_IDLE;
      cnt     <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      db_oe   <= 1'b0;
      ab      <= '0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata   <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt_q   <= gnt_port;
            we_q    <= gnt_port ? we1 : we0;
            wdata_q <= gnt_port ? wdata1 : wdata0;
            ab      <= gnt_port ? addr1 : addr0;
            db_oe   <= gnt_port ? we1 : we0;
            cs_n    <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt <= strobe_load(ACC_CYCLES);
          if (we_q) begin
            wr_n <= 1'b0;
          end else begin
            rd_n <= 1'b0;
          end
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            wr_n <= 1'b1;
            rd_n <= 1'b1;
            if (!we_q) begin
              rdata <= db;
            end
            ack0  <= ~gnt_q;
            ack1  <= gnt_q;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          cs_n  <= 1'b1;
          db_oe <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SRAM_BUS_ARBITER_STAT_EN
  // Completed-access counters, saturating; a clear beats a same-cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (stat_clr) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (state == ST_HOLD) begin
      if (we_q) begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end else begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
